// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 access codes,
// FSM state encoding and the captured-request payload.
package dmem_responder_pkg;

  // Load access codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store access codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Request as held from the accept cycle until the response is produced
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  func3;
  } dmem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational RV32I lane steering for the data-memory responder.
// Ports:
//   is_write       1 = store, 0 = load
//   func3          funct3 access code
//   addr_lo        byte offset within the word (addr[1:0])
//   ram_word       current contents of the addressed RAM word
//   wdata          right-aligned store data
//   load_data_c    extended load result (0 on error)
//   be_c           store byte enables (0 on error or load)
//   store_word_c   RAM word with the addressed store lanes merged in
//   err_c          misaligned access or illegal funct3
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic        is_write,
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] ram_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data_c,
  output logic [3:0]  be_c,
  output logic [31:0] store_word_c,
  output logic        err_c
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] wrep;

  assign lane_b = ram_word[{addr_lo, 3'b000} +: 8];
  assign lane_h = ram_word[{addr_lo[1], 4'b0000} +: 16];

  // Decode access size, alignment and extension
  always_comb begin
    load_data_c = '0;
    be_c        = '0;
    wrep        = wdata;
    err_c       = 1'b0;
    if (is_write) begin
      unique case (func3)
        F3_SB: begin
          wrep = {4{wdata[7:0]}};
          be_c = 4'b0001 << addr_lo;
        end
        F3_SH: begin
          wrep = {2{wdata[15:0]}};
          if (addr_lo[0]) err_c = 1'b1;
          else            be_c  = addr_lo[1] ? 4'b1100 : 4'b0011;
        end
        F3_SW: begin
          if (addr_lo != 2'b00) err_c = 1'b1;
          else                  be_c  = 4'b1111;
        end
        default: err_c = 1'b1;
      endcase
    end else begin
      unique case (func3)
        F3_LB:  load_data_c = {{24{lane_b[7]}}, lane_b};
        F3_LBU: load_data_c = {24'h0, lane_b};
        F3_LH: begin
          if (addr_lo[0]) err_c = 1'b1;
          else            load_data_c = {{16{lane_h[15]}}, lane_h};
        end
        F3_LHU: begin
          if (addr_lo[0]) err_c = 1'b1;
          else            load_data_c = {16'h0, lane_h};
        end
        F3_LW: begin
          if (addr_lo != 2'b00) err_c = 1'b1;
          else                  load_data_c = ram_word;
        end
        default: err_c = 1'b1;
      endcase
    end
  end

  // Merge replicated store data into the enabled byte lanes only
  always_comb begin
    store_word_c = ram_word;
    for (int i = 0; i < 4; i++) begin
      if (be_c[i]) store_word_c[8*i +: 8] = wrep[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the CPU data-memory port: accepts one load/store at a time
// over valid/ready, waits WAIT_STATES cycles, then serves it from a word RAM.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake
//   req_write              1 = store, 0 = load
//   req_addr               byte address (upper bits wrap)
//   req_wdata              right-aligned store data
//   req_func3              funct3 access code
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata              extended load data; 0 for stores and errors
//   rsp_err                misaligned access or illegal funct3
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W    = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam int unsigned CNT_INIT = (WAIT_STATES == 0) ? 0 : WAIT_STATES - 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  dmem_req_t         req_q;
  dmem_req_t         cur_req;
  logic              accept;
  logic              enter_resp;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       ram_word;
  logic [31:0]       load_data;
  logic [3:0]        be;
  logic [31:0]       store_word;
  logic              err;
  logic [31:0]       mem [DEPTH_WORDS];

  // Address bits above the RAM index wrap and are deliberately dropped
  logic unused_addr;
  assign unused_addr = ^{req_addr[31:IDX_W+2], req_q.addr[31:IDX_W+2]};

  assign accept     = req_valid && (state_q == ST_IDLE);
  assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

  // With zero wait states the response is built from the live request
  assign cur_req = accept ? '{write: req_write, addr: req_addr,
                              wdata: req_wdata, func3: req_func3}
                          : req_q;
  assign idx      = cur_req.addr[IDX_W+1:2];
  assign ram_word = mem[idx];

  dmem_lane_align u_align (
    .is_write     (cur_req.write),
    .func3        (cur_req.func3),
    .addr_lo      (cur_req.addr[1:0]),
    .ram_word     (ram_word),
    .wdata        (cur_req.wdata),
    .load_data_c  (load_data),
    .be_c         (be),
    .store_word_c (store_word),
    .err_c        (err)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt_q == '0) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Capture registers, wait counter and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q     <= '0;
      cnt_q     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        req_q <= cur_req;
        cnt_q <= CNT_W'(CNT_INIT);
      end else if (state_q == ST_WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (enter_resp) begin
        rsp_rdata <= cur_req.write ? 32'h0 : load_data;
        rsp_err   <= err;
      end
    end
  end

  // RAM write on the edge that enters RESP; contents are not reset
  always_ff @(posedge clk) begin
    if (enter_resp && cur_req.write && be != 4'b0000) mem[idx] <= store_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_STATES=2 and 0).
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_func3 = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_req_valid = 1'b0, z_req_write = 1'b0;
  logic [31:0] z_req_addr = '0, z_req_wdata = '0;
  logic [2:0]  z_req_func3 = '0;
  logic        z_req_ready, z_rsp_valid, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_func3(req_func3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dut_z (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_func3(z_req_func3),
    .rsp_valid(z_rsp_valid), .rsp_ready(1'b1),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One transaction on the WAIT_STATES=2 instance with rsp_ready held high
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f, output logic [31:0] rd,
                        output logic er, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_func3 = f;
    @(negedge clk);
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  task automatic ld(input string tag, input logic [31:0] a, input logic [2:0] f,
                    input logic [31:0] exp, input logic exp_err);
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, a, 32'h0, f, rd, er, lat);
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_data"}, rd, exp);
    check({tag, "_err"}, 32'(er), 32'(exp_err));
  endtask

  task automatic st(input string tag, input logic [31:0] a, input logic [31:0] d,
                    input logic [2:0] f, input logic exp_err);
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, a, d, f, rd, er, lat);
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_data"}, rd, 32'h0);
    check({tag, "_err"}, 32'(er), 32'(exp_err));
  endtask

  // One transaction on the WAIT_STATES=0 instance; response expected next cycle
  task automatic z_req(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f, input logic [31:0] exp);
    @(negedge clk);
    z_req_valid = 1'b1; z_req_write = w; z_req_addr = a; z_req_wdata = d; z_req_func3 = f;
    @(negedge clk);
    z_req_valid = 1'b0;
    check({tag, "_valid"}, 32'(z_rsp_valid), 32'd1);
    check({tag, "_data"}, z_rsp_rdata, exp);
    check({tag, "_err"}, 32'(z_rsp_err), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    int          wait_cnt;
    int          stray;

    // Reset held for three cycles
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_rsp_rdata", rsp_rdata,      32'h0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b1;

    // Word store/load
    st("sw10", 32'h10, 32'hDEAD_BEEF, F3_SW, 1'b0);
    ld("lw10", 32'h10, F3_LW, 32'hDEAD_BEEF, 1'b0);

    // Byte store into lane 3 -> word 0x7FADBEEF
    st("sb13", 32'h13, 32'h0000_007F, F3_SB, 1'b0);
    ld("lb13",  32'h13, F3_LB,  32'h0000_007F, 1'b0);
    ld("lbu13", 32'h13, F3_LBU, 32'h0000_007F, 1'b0);
    ld("lh12",  32'h12, F3_LH,  32'h0000_7FAD, 1'b0);
    ld("lb12",  32'h12, F3_LB,  32'hFFFF_FFAD, 1'b0);
    ld("lbu12", 32'h12, F3_LBU, 32'h0000_00AD, 1'b0);
    ld("lhu10", 32'h10, F3_LHU, 32'h0000_BEEF, 1'b0);
    st("sb13b", 32'h13, 32'hFFFF_FF80, F3_SB, 1'b0);
    ld("lb13b", 32'h13, F3_LB,  32'hFFFF_FF80, 1'b0);
    ld("lh12b", 32'h12, F3_LH,  32'hFFFF_80AD, 1'b0);

    // Misalignment and illegal funct3
    ld("lw12_mis", 32'h12, F3_LW, 32'h0, 1'b1);
    ld("lh11_mis", 32'h11, F3_LH, 32'h0, 1'b1);
    ld("l011_ill", 32'h10, 3'b011, 32'h0, 1'b1);
    st("sw20", 32'h20, 32'h1122_3344, F3_SW, 1'b0);
    st("sw22_mis", 32'h22, 32'hFFFF_FFFF, F3_SW, 1'b1);
    st("s100_ill", 32'h20, 32'hFFFF_FFFF, 3'b100, 1'b1);
    ld("lw20", 32'h20, F3_LW, 32'h1122_3344, 1'b0);
    st("sh22", 32'h22, 32'hAAAA_BEEF, F3_SH, 1'b0);
    ld("lw20b", 32'h20, F3_LW, 32'hBEEF_3344, 1'b0);
    // Address wrap: 1024 words -> 0x1020 aliases 0x20
    ld("lw_wrap", 32'h0000_1020, F3_LW, 32'hBEEF_3344, 1'b0);

    // Back-pressure: response held for 5 cycles, stray request ignored
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20; req_func3 = F3_LW;
    @(negedge clk);
    req_valid = 1'b0;
    wait_cnt = 1;
    while (!rsp_valid && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("bp_first", 32'(rsp_valid), 32'd1);
    held = rsp_rdata;
    check("bp_data", held, 32'hBEEF_3344);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
        req_wdata = 32'h0; req_func3 = F3_SW;
      end
      if (i == 2) req_valid = 1'b0;
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold",  rsp_rdata, held);
      check("bp_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_done_valid", 32'(rsp_valid), 32'd0);
    check("bp_done_ready", 32'(req_ready), 32'd1);
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) stray++;
    end
    check("bp_no_stray", 32'(stray), 32'd0);
    ld("lw20_after_bp", 32'h20, F3_LW, 32'hBEEF_3344, 1'b0);

    // Reset during WAIT aborts the store
    st("sw40", 32'h40, 32'hCAFE_F00D, F3_SW, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40;
    req_wdata = 32'h0000_1234; req_func3 = F3_SW;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rstw_valid", 32'(rsp_valid), 32'd0);
    check("rstw_ready", 32'(req_ready), 32'd1);
    rst = 1'b1;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) stray++;
    end
    check("rstw_no_rsp", 32'(stray), 32'd0);
    ld("lw40", 32'h40, F3_LW, 32'hCAFE_F00D, 1'b0);

    // Zero wait states: response one cycle after accept
    z_req("z_sw8",  1'b1, 32'h8, 32'hA5A5_0F0F, F3_SW, 32'h0);
    @(negedge clk);
    check("z_idle", 32'(z_rsp_valid), 32'd0);
    z_req("z_lw8",  1'b0, 32'h8, 32'h0, F3_LW, 32'hA5A5_0F0F);
    z_req("z_lba",  1'b0, 32'hA, 32'h0, F3_LB, 32'hFFFF_FFA5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
